// File: rtl/tdc_meas_ctrl_pkg.sv
// Shared constants and types for the TDC measurement sequencer: default widths,
// result field offsets and the FSM state encoding.
package tdc_meas_ctrl_pkg;

    localparam int TDC_NUM_TAPS    = 128;
    localparam int TDC_NUM_DECODE  = 7;
    localparam int TDC_COUNTER_DIG = 10;
    localparam int TDC_DIG_OUT     = TDC_COUNTER_DIG + 2 * TDC_NUM_DECODE;
    localparam int TDC_DEAD_CYCLES = 4;

    localparam int COARSE_LSB = 14;
    localparam int START_LSB  = 7;
    localparam int STOP_LSB   = 0;

    localparam logic [7:0] MISS_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_MEAS,
        ST_OUT,
        ST_DEAD
    } state_t;

endpackage

// File: rtl/tdc_meas_ctrl_if.sv
// Control/result bundle between the TDC sequencer and its front end / consumer.
interface tdc_meas_ctrl_if #(
    parameter int NUM_DECODE = 7,
    parameter int DIG_OUT    = 24
);
    logic                  enable;
    logic                  start_det;
    logic [NUM_DECODE-1:0] start_fine;
    logic                  stop_det;
    logic [NUM_DECODE-1:0] stop_fine;
    logic                  arm;
    logic [DIG_OUT-1:0]    tdc;
    logic                  valid;
    logic                  rdy;
    logic                  overflow;
    logic [7:0]            miss_cnt;
    logic                  busy;

    modport master (
        output enable, start_det, start_fine, stop_det, stop_fine, rdy,
        input  arm, tdc, valid, overflow, miss_cnt, busy
    );

    modport slave (
        input  enable, start_det, start_fine, stop_det, stop_fine, rdy,
        output arm, tdc, valid, overflow, miss_cnt, busy
    );
endinterface

// File: rtl/tdc_meas_ctrl_coarse_cnt.sv
// Coarse cycle counter between start and stop events; terminal flags the all-ones value.
module tdc_coarse_cnt #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == '1);
endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arms capture, times start->stop in clock cycles, packs
// {coarse, start fine, stop fine} and hands it off on valid/ready, then enforces dead time.
module tdc_meas_ctrl
    import tdc_meas_ctrl_pkg::*;
#(
    parameter int NUM_DECODE  = TDC_NUM_DECODE,
    parameter int COUNTER_DIG = TDC_COUNTER_DIG,
    parameter int DIG_OUT     = TDC_DIG_OUT,
    parameter int DEAD_CYCLES = TDC_DEAD_CYCLES
) (
    input logic             clk,
    input logic             rst,
    tdc_meas_ctrl_if.slave  bus
);
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    generate
        if (DIG_OUT != COUNTER_DIG + 2 * NUM_DECODE) begin : g_bad_width
            $error("tdc_meas_ctrl: DIG_OUT must equal COUNTER_DIG + 2*NUM_DECODE");
        end
        if (DEAD_CYCLES < 1) begin : g_bad_dead
            $error("tdc_meas_ctrl: DEAD_CYCLES must be at least 1");
        end
    endgenerate

    state_t                 state;
    logic                   arm;
    logic [DIG_OUT-1:0]     tdc;
    logic                   valid;
    logic                   overflow;
    logic [7:0]             miss_cnt;
    logic                   busy;
    logic [NUM_DECODE-1:0]  start_q;
    logic [DW-1:0]          dead_cnt;
    logic [COUNTER_DIG-1:0] coarse;
    logic                   coarse_tc;
    logic                   cnt_en;
    logic                   missable;

    // The start cycle itself counts, so a stop k cycles after start sees coarse == k.
    assign cnt_en   = (state == ST_MEAS) || (state == ST_ARMED && bus.start_det);
    assign missable = (state == ST_IDLE) || (state == ST_OUT) || (state == ST_DEAD);

    tdc_coarse_cnt #(.WIDTH(COUNTER_DIG)) u_coarse (
        .clk      (clk),
        .rst      (rst),
        .clear    (!cnt_en),
        .en       (cnt_en),
        .count    (coarse),
        .terminal (coarse_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            arm      <= 1'b0;
            tdc      <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            miss_cnt <= '0;
            busy     <= 1'b0;
            start_q  <= '0;
            dead_cnt <= '0;
        end else begin
            overflow <= 1'b0;
            if (bus.start_det && missable && miss_cnt != MISS_MAX) begin
                miss_cnt <= miss_cnt + 8'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state <= ST_ARMED;
                        arm   <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!bus.enable) begin
                        state <= ST_IDLE;
                        arm   <= 1'b0;
                    end else if (bus.start_det && bus.stop_det) begin
                        state <= ST_OUT;
                        arm   <= 1'b0;
                        busy  <= 1'b1;
                        valid <= 1'b1;
                        tdc   <= {{COUNTER_DIG{1'b0}}, bus.start_fine, bus.stop_fine};
                    end else if (bus.start_det) begin
                        state   <= ST_MEAS;
                        busy    <= 1'b1;
                        start_q <= bus.start_fine;
                    end
                end
                ST_MEAS: begin
                    if (!bus.enable) begin
                        state <= ST_IDLE;
                        arm   <= 1'b0;
                        busy  <= 1'b0;
                    end else if (bus.stop_det) begin
                        state <= ST_OUT;
                        arm   <= 1'b0;
                        valid <= 1'b1;
                        tdc   <= {coarse, start_q, bus.stop_fine};
                    end else if (coarse_tc) begin
                        state    <= ST_DEAD;
                        arm      <= 1'b0;
                        overflow <= 1'b1;
                        dead_cnt <= DW'(DEAD_CYCLES - 1);
                    end
                end
                ST_OUT: begin
                    if (bus.rdy) begin
                        state    <= ST_DEAD;
                        valid    <= 1'b0;
                        dead_cnt <= DW'(DEAD_CYCLES - 1);
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= bus.enable ? ST_ARMED : ST_IDLE;
                        arm   <= bus.enable;
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    arm   <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arm      = arm;
    assign bus.tdc      = tdc;
    assign bus.valid    = valid;
    assign bus.overflow = overflow;
    assign bus.miss_cnt = miss_cnt;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl; results are queued at stimulus time and popped on handshake.
module tb_tdc_meas_ctrl;
    import tdc_meas_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdc_meas_ctrl_if #(.NUM_DECODE(7), .DIG_OUT(24)) bus ();

    tdc_meas_ctrl #(
        .NUM_DECODE  (7),
        .COUNTER_DIG (10),
        .DIG_OUT     (24),
        .DEAD_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          exp_miss  = 0;
    int          transfers = 0;
    logic [23:0] exp_q[$];
    logic [23:0] popped;

    function automatic logic [23:0] res(input int c, input int s, input int p);
        logic [23:0] r;
        r = 24'((c & 32'h3FF) << COARSE_LSB) | 24'((s & 32'h7F) << START_LSB)
          | 24'((p & 32'h7F) << STOP_LSB);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_arm"}, 32'(bus.arm), 32'd0);
        check({tag, "_tdc"}, 32'(bus.tdc), 32'd0);
        check({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
        check({tag, "_miss"}, 32'(bus.miss_cnt), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_arm(input string tag, input int bound);
        int n = 0;
        while (bus.arm !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.arm), 32'd1);
    endtask

    // Handshake completes on the next rising edge when valid and rdy are both high here.
    always @(negedge clk) begin
        if (!rst && bus.valid === 1'b1 && bus.rdy === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0)
            else begin
                failures++;
                $error("FAIL unexpected_valid observed tdc=0x%0h expected no result", bus.tdc);
            end
            if (exp_q.size() > 0) begin
                popped = exp_q.pop_front();
                check("tdc_result", 32'(bus.tdc), 32'(popped));
                transfers++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          early;
        int          unstable;
        logic [23:0] exp4;

        bus.enable     = 1'b0;
        bus.start_det  = 1'b0;
        bus.start_fine = '0;
        bus.stop_det   = 1'b0;
        bus.stop_fine  = '0;
        bus.rdy        = 1'b1;

        tick();
        tick();
        check_reset("reset");

        rst        = 1'b0;
        bus.enable = 1'b1;
        tick();
        check("idle_to_armed", 32'(bus.arm), 32'd1);
        check("armed_not_busy", 32'(bus.busy), 32'd0);

        // 1: stop five cycles after start
        exp_q.push_back(res(5, 37, 12));
        bus.start_det = 1'b1; bus.start_fine = 7'd37;
        tick();
        bus.start_det = 1'b0;
        check("t1_meas_busy", 32'(bus.busy), 32'd1);
        repeat (4) tick();
        bus.stop_det = 1'b1; bus.stop_fine = 7'd12;
        tick();
        bus.stop_det = 1'b0;
        check("t1_latency_valid", 32'(bus.valid), 32'd1);
        check("t1_out_arm", 32'(bus.arm), 32'd0);
        tick();
        check("t1_one_cycle_valid", 32'(bus.valid), 32'd0);
        repeat (3) tick();
        check("t1_dead_arm", 32'(bus.arm), 32'd0);
        tick();
        check("t1_rearm", 32'(bus.arm), 32'd1);

        // 2: zero interval
        exp_q.push_back(res(0, 3, 100));
        bus.start_det = 1'b1; bus.start_fine = 7'd3;
        bus.stop_det  = 1'b1; bus.stop_fine  = 7'd100;
        tick();
        bus.start_det = 1'b0; bus.stop_det = 1'b0;
        check("t2_latency_valid", 32'(bus.valid), 32'd1);
        tick();
        check("t2_valid_drop", 32'(bus.valid), 32'd0);
        wait_arm("t2_rearm", 10);

        // 3: runaway start
        bus.start_det = 1'b1; bus.start_fine = 7'd9;
        tick();
        bus.start_det = 1'b0;
        early = 0;
        repeat (1022) begin
            tick();
            if (bus.overflow !== 1'b0 || bus.valid !== 1'b0) early++;
        end
        check("t3_no_early_event", 32'(early), 32'd0);
        tick();
        check("t3_overflow_pulse", 32'(bus.overflow), 32'd1);
        check("t3_no_valid", 32'(bus.valid), 32'd0);
        check("t3_dead_busy", 32'(bus.busy), 32'd1);
        repeat (3) tick();
        check("t3_overflow_ends", 32'(bus.overflow), 32'd0);
        check("t3_dead_arm", 32'(bus.arm), 32'd0);
        tick();
        check("t3_rearm", 32'(bus.arm), 32'd1);

        // 4: back-pressure with misses while result pending
        bus.rdy = 1'b0;
        exp4 = res(2, 50, 60);
        exp_q.push_back(exp4);
        bus.start_det = 1'b1; bus.start_fine = 7'd50;
        tick();
        bus.start_det = 1'b0;
        tick();
        bus.stop_det = 1'b1; bus.stop_fine = 7'd60;
        tick();
        bus.stop_det = 1'b0;
        check("t4_valid", 32'(bus.valid), 32'd1);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 6 == 1) begin
                bus.start_det  = 1'b1;
                bus.start_fine = 7'(i);
                exp_miss++;
            end
            tick();
            bus.start_det = 1'b0;
            if (bus.valid !== 1'b1 || bus.tdc !== exp4) unstable++;
        end
        check("t4_held_stable", 32'(unstable), 32'd0);
        check("t4_miss_cnt", 32'(bus.miss_cnt), 32'(exp_miss));
        bus.rdy = 1'b1;
        tick();
        check("t4_valid_drop", 32'(bus.valid), 32'd0);
        repeat (3) tick();
        check("t4_dead_arm", 32'(bus.arm), 32'd0);
        tick();
        check("t4_rearm", 32'(bus.arm), 32'd1);

        // 5: disable mid-measurement, then saturate the miss counter
        bus.start_det = 1'b1; bus.start_fine = 7'd5;
        tick();
        bus.start_det = 1'b0;
        repeat (2) tick();
        bus.enable = 1'b0;
        tick();
        check("t5_idle_arm", 32'(bus.arm), 32'd0);
        check("t5_idle_busy", 32'(bus.busy), 32'd0);
        early = 0;
        repeat (5) begin
            tick();
            if (bus.overflow !== 1'b0 || bus.valid !== 1'b0) early++;
        end
        check("t5_no_output", 32'(early), 32'd0);
        bus.start_det = 1'b1;
        repeat (300) begin
            tick();
            if (exp_miss < 255) exp_miss++;
        end
        bus.start_det = 1'b0;
        check("t5_miss_saturate", 32'(bus.miss_cnt), 32'(exp_miss));

        // 6: reset in MEAS and in OUT
        bus.enable = 1'b1;
        tick();
        bus.start_det = 1'b1; bus.start_fine = 7'd40;
        tick();
        bus.start_det = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_reset("t6_rst_meas");
        exp_miss = 0;
        rst = 1'b0;
        tick();
        check("t6_rearm_a", 32'(bus.arm), 32'd1);
        bus.rdy = 1'b0;
        bus.start_det = 1'b1; bus.start_fine = 7'd11;
        tick();
        bus.start_det = 1'b0;
        repeat (2) tick();
        bus.stop_det = 1'b1; bus.stop_fine = 7'd22;
        tick();
        bus.stop_det = 1'b0;
        check("t6_pending_valid", 32'(bus.valid), 32'd1);
        rst = 1'b1;
        tick();
        check_reset("t6_rst_out");
        rst     = 1'b0;
        bus.rdy = 1'b1;
        tick();
        check("t6_rearm_b", 32'(bus.arm), 32'd1);
        exp_q.push_back(res(1, 1, 2));
        bus.start_det = 1'b1; bus.start_fine = 7'd1;
        tick();
        bus.start_det = 1'b0;
        bus.stop_det = 1'b1; bus.stop_fine = 7'd2;
        tick();
        bus.stop_det = 1'b0;
        check("t6_clean_valid", 32'(bus.valid), 32'd1);
        tick();
        wait_arm("t6_final_rearm", 10);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("transfer_count", 32'(transfers), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
